result_packer: RTL and testbench
================================

Name: result_packer

Overview:
- Sits directly downstream of the core result path, between the accumulator readout and the AXI-Stream master output.
- Accepts a sequence of 32-bit result words over a valid/ready handshake and packs them in pairs into 64-bit stream beats.
- Frames each packet with TLAST after a programmed beat count.
- Decouples core readout from M_AXIS_TREADY back-pressure with a small beat FIFO.

Parameters:
- DEPTH, 4, number of 64-bit beats the output FIFO holds (power of two, at least 2).
- LEN_W, 16, width of the beat-count register.

Ports:
- clk  in  1  stream clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a packet; honoured only in IDLE.
- beat_num  in  LEN_W  packet length minus one, in 64-bit beats; sampled on start.
- res_valid  in  1  result word valid.
- res_data  in  32  result word.
- res_ready  out  1  result word accepted when res_valid & res_ready.
- dst_valid  out  1  stream beat valid (drives M_AXIS_TVALID).
- dst_data  out  64  stream beat (drives M_AXIS_TDATA).
- dst_strb  out  8  byte strobes (drives M_AXIS_TSTRB).
- dst_last  out  1  final beat of the packet (drives M_AXIS_TLAST).
- dst_ready  in  1  downstream ready (from M_AXIS_TREADY).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the last beat leaves the FIFO.

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset values: state IDLE, FIFO empty, half-word flag cleared, beat counter 0. res_ready, dst_valid, dst_last, busy and done are all 0; dst_data is 0; dst_strb is 8'hff.
- Reset mid-packet: discards all pending words and beats, with no output glitch after reset deasserts.
- IDLE: res_ready=0. On start, latch beat_num, clear the beat counter and half flag, and go to RUN. res_valid is ignored in IDLE, so words are neither accepted nor dropped.
- RUN, handshake:
  - res_ready = ~fifo_full.
  - First accepted word of a pair goes into a lo register and sets half.
  - Second accepted word pushes {res_data, lo} into the FIFO: bits [63:32] are the second word, [31:0] the first.
  - The pushed beat carries last = (beat_cnt == beat_num_latched); beat_cnt then increments.
- RUN, end of packet: pushing the last beat moves the block to DRAIN.
- DRAIN: res_ready=0. When the FIFO is empty after its last pop, go to IDLE and pulse done in that same cycle.
- A start pulse in RUN or DRAIN is ignored.
- Full condition: push is permitted only when not full. A pop in the same cycle does not free a slot (registered full).
- Empty condition: dst_valid = ~fifo_empty. Output is show-ahead: dst_data and dst_last come from the head entry.
- Pop: occurs on dst_valid & dst_ready.
- Simultaneous push and pop when non-full and non-empty: both occur; occupancy is unchanged.
- Latency: second word accepted at cycle N gives dst_valid at N+1 if the FIFO was empty.
- Stream stability: dst_data and dst_last hold stable while dst_valid & ~dst_ready.
- beat_num=0: one beat, two words, with dst_last set on that beat.
- Widths: beat_cnt is LEN_W bits, so beat_num = 2^LEN_W-1 is supported without counter overflow. The comparison is on equality only.

Optional Feature:
- Macro: RESULT_PACKER_FLUSH_EN.
- With the macro:
  - Adds input port flush (1 bit).
  - flush in RUN with half=1 pushes {32'h0, lo} with strb 8'h0f and last=1, then moves to DRAIN.
  - flush in RUN with half=0 marks the most recently pushed beat as not re-sent, pushes nothing, and sets last on the next push only. If no beat was pushed yet, it goes directly to IDLE without done.
  - The FIFO entry width grows to carry the strb selector.
- Without the macro: there is no flush port, and dst_strb is constant 8'hff.

Decomposition:
- Shared package hpu_pkg holds:
  - the state encoding (IDLE, RUN, DRAIN as a 2-bit typedef);
  - constants STRB_FULL=8'hff and STRB_LO=8'h0f;
  - the RESULT_W=32 and STREAM_W=64 widths.
- One sub-module is natural: beat_fifo, a synchronous show-ahead FIFO of DEPTH x (64+1[+1]) bits with push, pop, full and empty, instantiated once.

Test Plan:
- start with beat_num=0; words 0x11111111 then 0x22222222; dst_ready=1 -> one beat 0x22222222_11111111, dst_last=1, done one cycle after the pop, busy back to 0.
- beat_num=3; 8 words 1..8 streamed back-to-back -> beats {2,1},{4,3},{6,5},{8,7}; dst_last only on the fourth beat.
- beat_num=7, dst_ready=0 throughout -> res_ready drops after 8 words (DEPTH=4 full). Then raise dst_ready -> no beat lost or duplicated, and the remaining 8 words are accepted.
- Assert rst midway through a beat_num=3 packet after 5 words -> dst_valid=0 immediately. A fresh start with beat_num=0 then yields a single correct beat with no stale data.
- Pulse start again during RUN with a different beat_num -> ignored; the original packet length is preserved.
- With RESULT_PACKER_FLUSH_EN: beat_num=3; 3 words A,B,C; then flush -> beats {B,A} strb ff last 0, then {0,C} strb 0f last 1, then done.

Source files
------------

// File: rtl/hpu_pkg.sv
// Shared types and constants for the result packer.
// RESULT_PACKER_FLUSH_EN adds a strobe selector bit to each stored beat.
package hpu_pkg;

  localparam int unsigned RESULT_W = 32;
  localparam int unsigned STREAM_W = 64;

  localparam logic [7:0] STRB_FULL = 8'hff;
  localparam logic [7:0] STRB_LO   = 8'h0f;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
`ifdef RESULT_PACKER_FLUSH_EN
    logic                strb_lo;
`endif
    logic                last;
    logic [STREAM_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/result_packer_beat_fifo.sv
// Synchronous show-ahead FIFO; full/empty decoded from the registered count,
// so a pop never frees a slot for a push in the same cycle.
module beat_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/result_packer.sv
// Packs pairs of 32-bit result words into framed 64-bit stream beats.
// Optional RESULT_PACKER_FLUSH_EN adds a flush input that closes a packet early.
module result_packer
  import hpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    beat_num,
  input  logic                res_valid,
  input  logic [RESULT_W-1:0] res_data,
  output logic                res_ready,
  output logic                dst_valid,
  output logic [STREAM_W-1:0] dst_data,
  output logic [7:0]          dst_strb,
  output logic                dst_last,
  input  logic                dst_ready,
`ifdef RESULT_PACKER_FLUSH_EN
  input  logic                flush,
`endif
  output logic                busy,
  output logic                done
);

  state_t              state_q, state_d;
  logic                half_q, half_d;
  logic [RESULT_W-1:0] lo_q, lo_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    num_q, num_d;
  logic                push;
  beat_t               push_beat;
  beat_t               head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                end_beat;
`ifdef RESULT_PACKER_FLUSH_EN
  logic                force_last_q, force_last_d;
  logic                pend_q, pend_d;
  logic                flush_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      half_q  <= 1'b0;
      lo_q    <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
`ifdef RESULT_PACKER_FLUSH_EN
      force_last_q <= 1'b0;
      pend_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
`ifdef RESULT_PACKER_FLUSH_EN
      force_last_q <= force_last_d;
      pend_q       <= pend_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    push      = 1'b0;
    push_beat = '0;
    res_ready = 1'b0;
    done      = 1'b0;
    end_beat  = 1'b0;
`ifdef RESULT_PACKER_FLUSH_EN
    force_last_d = force_last_q;
    pend_d       = pend_q;
    flush_req    = flush | pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = beat_num;
          cnt_d   = '0;
          half_d  = 1'b0;
          state_d = RUN;
`ifdef RESULT_PACKER_FLUSH_EN
          force_last_d = 1'b0;
          pend_d       = 1'b0;
`endif
        end
      end
      RUN: begin
        res_ready = ~fifo_full;
`ifdef RESULT_PACKER_FLUSH_EN
        // A flush that closes or abandons the packet blocks further words.
        if (flush_req && (half_q || cnt_q == '0)) res_ready = 1'b0;
`endif
        if (res_valid && res_ready) begin
          if (!half_q) begin
            lo_d   = res_data;
            half_d = 1'b1;
          end else begin
            end_beat = (cnt_q == num_q);
`ifdef RESULT_PACKER_FLUSH_EN
            end_beat = end_beat | force_last_q;
`endif
            push           = 1'b1;
            push_beat.data = {res_data, lo_q};
            push_beat.last = end_beat;
            half_d         = 1'b0;
            cnt_d          = cnt_q + LEN_W'(1);
            if (end_beat) state_d = DRAIN;
          end
        end
`ifdef RESULT_PACKER_FLUSH_EN
        if (flush_req) begin
          pend_d = 1'b0;
          if (half_q) begin
            // Pad the dangling word into a half beat; wait for space if full.
            if (!fifo_full) begin
              push              = 1'b1;
              push_beat.data    = {32'h0, lo_q};
              push_beat.last    = 1'b1;
              push_beat.strb_lo = 1'b1;
              half_d            = 1'b0;
              state_d           = DRAIN;
            end else begin
              pend_d = 1'b1;
            end
          end else if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            force_last_d = 1'b1;
          end
        end
`endif
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop = dst_valid & dst_ready;

  beat_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(beat_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_beat),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy      = (state_q != IDLE);
  assign dst_valid = ~fifo_empty;
  assign dst_data  = head.data;
  assign dst_last  = head.last;
`ifdef RESULT_PACKER_FLUSH_EN
  assign dst_strb  = head.strb_lo ? STRB_LO : STRB_FULL;
`else
  assign dst_strb  = STRB_FULL;
`endif

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer; expected beats are formed by pairing
// the word list directly, with TLAST on beat index beat_num.
`timescale 1ns/1ps
module tb_result_packer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] beat_num;
  logic             res_valid;
  logic [31:0]      res_data;
  logic             res_ready;
  logic             dst_valid;
  logic [63:0]      dst_data;
  logic [7:0]       dst_strb;
  logic             dst_last;
  logic             dst_ready;
  logic             busy;
  logic             done;
`ifdef RESULT_PACKER_FLUSH_EN
  logic             flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] words[$];

  always #5 clk = ~clk;

  result_packer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .beat_num  (beat_num),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
    .dst_strb  (dst_strb),
    .dst_last  (dst_last),
    .dst_ready (dst_ready),
`ifdef RESULT_PACKER_FLUSH_EN
    .flush     (flush),
`endif
    .busy      (busy),
    .done      (done)
  );

  // Runs one packet from the words queue with random valid/ready duty cycles.
  // hold: dst_ready forced low for that many cycles; restart_at: cycle of a stray start.
  task automatic run_packet(input int num, input int pv, input int pr,
                            input int hold, input int restart_at);
    logic [63:0] exp_data[$];
    bit          exp_last[$];
    int nw, wi, bi, last_pop;
    bit done_seen, prev_stall, prev_last;
    logic [63:0] prev_data;
    nw = words.size();
    for (int i = 0; i < nw / 2; i++) begin
      exp_data.push_back({words[2*i+1], words[2*i]});
      exp_last.push_back(i == num);
    end
    wi = 0; bi = 0; last_pop = -10; done_seen = 0; prev_stall = 0;
    prev_data = '0; prev_last = 0;
    for (int c = 0; c < 3000 && !done_seen; c++) begin
      @(negedge clk);
      start     = (c == 0) || (c == restart_at);
      beat_num  = (c == 0) ? LEN_W'(num) : LEN_W'(num + 2);
      res_valid = (wi < nw) && ($urandom_range(99) < pv);
      res_data  = (wi < nw) ? words[wi] : $urandom;
      dst_ready = (c >= hold) && ($urandom_range(99) < pr);
      #1;
      if (hold > 0 && c == hold - 1) begin
        checks++;
        if (wi != 2 * DEPTH || res_ready !== 1'b0) begin
          errors++;
          $display("FAIL backpressure_accept: got %0d words res_ready=%b, want %0d words res_ready=0",
                   wi, res_ready, 2 * DEPTH);
        end
      end
      if (res_valid && res_ready) wi++;
      if (prev_stall) begin
        checks++;
        if (dst_valid !== 1'b1 || dst_data !== prev_data || dst_last !== prev_last) begin
          errors++;
          $display("FAIL stall_stable: got v=%b %h l=%b, want v=1 %h l=%b",
                   dst_valid, dst_data, dst_last, prev_data, prev_last);
        end
      end
      if (dst_valid && dst_ready) begin
        checks++;
        if (bi >= exp_data.size()) begin
          errors++;
          $display("FAIL extra_beat: got beat %h, want no beat", dst_data);
        end else if (dst_data !== exp_data[bi] || dst_last !== exp_last[bi] ||
                     dst_strb !== 8'hff) begin
          errors++;
          $display("FAIL beat%0d: got %h last=%b strb=%h, want %h last=%b strb=ff",
                   bi, dst_data, dst_last, dst_strb, exp_data[bi], exp_last[bi]);
        end
        bi++;
        last_pop = c;
      end
      prev_stall = dst_valid && !dst_ready;
      prev_data  = dst_data;
      prev_last  = dst_last;
      if (done) begin
        done_seen = 1;
        checks++;
        if (c != last_pop + 1 || bi != exp_data.size()) begin
          errors++;
          $display("FAIL done_timing: got done at %0d after %0d beats, want %0d after %0d beats",
                   c, bi, last_pop + 1, exp_data.size());
        end
      end
    end
    start = 0; res_valid = 0; dst_ready = 0;
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL done_timeout: got no done, want done");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dst_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after: got busy=%b dst_valid=%b, want 0 0", busy, dst_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; beat_num = '0; res_valid = 0; res_data = '0; dst_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({res_ready, dst_valid, dst_last, busy, done} !== 5'b0 || dst_data !== 64'h0 ||
        dst_strb !== 8'hff) begin
      errors++;
      $display("FAIL reset_vals: got rr=%b v=%b l=%b busy=%b done=%b d=%h s=%h, want 0 0 0 0 0 0 ff",
               res_ready, dst_valid, dst_last, busy, done, dst_data, dst_strb);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    checks++;
    if (res_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got rr=%b busy=%b, want 0 0", res_ready, busy);
    end
  endtask

  task automatic test_single();
    words = '{32'h11111111, 32'h22222222};
    run_packet(0, 100, 100, 0, -1);
  endtask

  task automatic test_back_to_back();
    words = '{};
    for (int i = 1; i <= 8; i++) words.push_back(32'(i));
    run_packet(3, 100, 100, 0, -1);
  endtask

  task automatic test_backpressure();
    words = '{};
    for (int i = 0; i < 16; i++) words.push_back($urandom);
    run_packet(7, 100, 100, 20, -1);
  endtask

  task automatic test_restart_ignored();
    words = '{};
    for (int i = 0; i < 8; i++) words.push_back($urandom);
    run_packet(3, 70, 60, 0, 3);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1; beat_num = LEN_W'(3);
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 5; i++) begin
      res_valid = 1; res_data = 32'hdead0000 + 32'(i);
      @(negedge clk);
    end
    res_valid = 0;
    rst = 1;
    #1;
    checks++;
    if (dst_valid !== 1'b0 || busy !== 1'b0 || res_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b busy=%b rr=%b, want 0 0 0", dst_valid, busy, res_ready);
    end
    @(negedge clk);
    rst = 0;
    words = '{32'hcafe0001, 32'hcafe0002};
    run_packet(0, 100, 100, 0, -1);
  endtask

  task automatic test_random();
    int num;
    for (int k = 0; k < 4; k++) begin
      num = int'($urandom_range(5));
      words = '{};
      for (int i = 0; i < 2 * (num + 1); i++) words.push_back($urandom);
      run_packet(num, int'($urandom_range(100, 40)), int'($urandom_range(100, 30)), 0, -1);
    end
  endtask

`ifdef RESULT_PACKER_FLUSH_EN
  task automatic test_flush();
    logic [63:0] exp_d[2];
    logic [7:0]  exp_s[2];
    bit          exp_l[2];
    int bi;
    bit seen;
    exp_d[0] = {32'hbbbbbbbb, 32'haaaaaaaa}; exp_s[0] = 8'hff; exp_l[0] = 0;
    exp_d[1] = {32'h0, 32'hcccccccc};         exp_s[1] = 8'h0f; exp_l[1] = 1;
    words = '{32'haaaaaaaa, 32'hbbbbbbbb, 32'hcccccccc};
    bi = 0; seen = 0;
    @(negedge clk);
    start = 1; beat_num = LEN_W'(3); dst_ready = 1;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      start = 0;
      res_valid = (words.size() > 0);
      res_data  = (words.size() > 0) ? words[0] : '0;
      flush     = (c == 4);
      #1;
      if (res_valid && res_ready) void'(words.pop_front());
      if (dst_valid && dst_ready) begin
        checks++;
        if (bi > 1 || dst_data !== exp_d[bi] || dst_strb !== exp_s[bi] || dst_last !== exp_l[bi]) begin
          errors++;
          $display("FAIL flush_beat%0d: got %h s=%h l=%b", bi, dst_data, dst_strb, dst_last);
        end
        bi++;
      end
      if (done) seen = 1;
    end
    flush = 0; res_valid = 0; dst_ready = 0;
    checks++;
    if (!seen || bi != 2) begin
      errors++;
      $display("FAIL flush_done: got done=%b beats=%0d, want 1 2", seen, bi);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_restart_ignored();
    test_random();
`ifdef RESULT_PACKER_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
